// File: rtl/inst_encoder_pkg.sv
// Shared types for the RV32I instruction encoder: decoded operation enum,
// encoder error codes, base opcodes and a few packing helpers.
package inst_encoder_pkg;

   typedef enum logic [5:0] {
      ERROR, NOP, LUI, AUIPC, JAL, JALR,
      BEQ, BNE, BLT, BGE, BLTU, BGEU,
      LB, LH, LW, LBU, LHU, SB, SH, SW,
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
      FENCE, ECALL, EBREAK
   } RiscvInstructions;

   typedef enum logic [1:0] {ENC_OK, ENC_BAD_OP, ENC_RANGE, ENC_ALIGN} EncErrCode;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   // True when value, read as signed, is representable in 'width' two's-complement bits.
   function automatic logic fits_signed(input logic [31:0] value, input int width);
      logic signed [31:0] s;
      int lim;
      s   = value;
      lim = 1 << (width - 1);
      return (s >= -lim) && (s < lim);
   endfunction

   function automatic logic [2:0] funct3_of(input RiscvInstructions op);
      case (op)
         BNE, LH, SH, SLLI, SLL:              return 3'b001;
         LW, SW, SLTI, SLT:                   return 3'b010;
         SLTIU, SLTU:                         return 3'b011;
         BLT, LBU, XORI, XOR:                 return 3'b100;
         BGE, LHU, SRLI, SRAI, SRL, SRA:      return 3'b101;
         BLTU, ORI, OR:                       return 3'b110;
         BGEU, ANDI, AND:                     return 3'b111;
         default:                             return 3'b000;
      endcase
   endfunction

endpackage

// File: rtl/inst_pack.sv
// Combinational packer: one decoded operation plus fields -> RV32I word,
// with an error code when the operation or immediate cannot be encoded.
module inst_pack
   import inst_encoder_pkg::*;
(
   input  RiscvInstructions operation,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   input  logic [31:0]      imm,
   output logic [31:0]      instruction,
   output EncErrCode        err_code
);

   logic [2:0] f3;
   assign f3 = funct3_of(operation);

   always_comb begin
      instruction = 32'h0000_0000;
      err_code    = ENC_OK;
      case (operation)
         NOP:    instruction = 32'h0000_0033;
         ECALL:  instruction = 32'h0000_0073;
         EBREAK: instruction = 32'h0010_0073;
         FENCE:  instruction = {imm[11:0], 13'b0, OPC_FENCE};
         LUI:    instruction = {imm[31:12], rd, OPC_LUI};
         AUIPC:  instruction = {imm[31:12], rd, OPC_AUIPC};
         JAL: begin
            if (imm[0])                     err_code = ENC_ALIGN;
            else if (!fits_signed(imm, 21)) err_code = ENC_RANGE;
            instruction = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
         end
         JALR: begin
            if (!fits_signed(imm, 12)) err_code = ENC_RANGE;
            instruction = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
         end
         BEQ, BNE, BLT, BGE, BLTU, BGEU: begin
            if (imm[0])                     err_code = ENC_ALIGN;
            else if (!fits_signed(imm, 13)) err_code = ENC_RANGE;
            instruction = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
         end
         LB, LH, LW, LBU, LHU: begin
            if (!fits_signed(imm, 12)) err_code = ENC_RANGE;
            instruction = {imm[11:0], rs1, f3, rd, OPC_LOAD};
         end
         SB, SH, SW: begin
            if (!fits_signed(imm, 12)) err_code = ENC_RANGE;
            instruction = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
         end
         ADDI, SLTI, SLTIU, XORI, ORI, ANDI: begin
            if (!fits_signed(imm, 12)) err_code = ENC_RANGE;
            instruction = {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
         end
         SLLI, SRLI, SRAI: begin
            if (imm[31:5] != 27'd0) err_code = ENC_RANGE;
            instruction = {(operation == SRAI) ? 7'b0100000 : 7'b0000000,
                           imm[4:0], rs1, f3, rd, OPC_OP_IMM};
         end
         ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND:
            instruction = {(operation == SUB || operation == SRA) ? 7'b0100000 : 7'b0000000,
                           rs2, rs1, f3, rd, OPC_OP};
         default: err_code = ENC_BAD_OP;
      endcase
   end

endmodule

// File: rtl/inst_encoder.sv
// Instruction encoder: accepts decoded operations, packs them to RV32I words
// and streams them through a 2-entry buffer with an auto-incrementing address.
module inst_encoder
   import inst_encoder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          COUNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  RiscvInstructions   in_operation,
   input  logic [4:0]         in_rd,
   input  logic [4:0]         in_rs1,
   input  logic [4:0]         in_rs2,
   input  logic [31:0]        in_imm,
   input  logic               addr_load_en,
   input  logic [31:0]        addr_load_value,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_instruction,
   output logic [31:0]        out_addr,
   output logic               err_valid,
   output EncErrCode          err_code,
   output logic               err_sticky,
   output logic [COUNT_W-1:0] word_count
);

   logic [31:0] pack_word;
   EncErrCode   pack_err;
   logic [31:0] entry1;
   logic [1:0]  count;
   logic [1:0]  count_next;
   logic        accept;
   logic        push;
   logic        pop;

   inst_pack u_pack (
      .operation   (in_operation),
      .rd          (in_rd),
      .rs1         (in_rs1),
      .rs2         (in_rs2),
      .imm         (in_imm),
      .instruction (pack_word),
      .err_code    (pack_err)
   );

   assign accept     = in_valid & in_ready;
   assign push       = accept & (pack_err == ENC_OK);
   assign pop        = out_valid & out_ready;
   assign out_valid  = (count != 2'd0);
   assign count_next = count + {1'b0, push} - {1'b0, pop};

   // out_instruction is the head entry itself; entry1 is the slot behind it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count           <= 2'd0;
         in_ready        <= 1'b1;
         out_instruction <= 32'h0000_0000;
         entry1          <= 32'h0000_0000;
      end else begin
         count    <= count_next;
         in_ready <= (count_next != 2'd2);
         if (pop) begin
            if (push && count == 2'd1) out_instruction <= pack_word;
            else                       out_instruction <= entry1;
            if (push && count == 2'd2) entry1 <= pack_word;
         end else if (push) begin
            if (count == 2'd0) out_instruction <= pack_word;
            else               entry1 <= pack_word;
         end
      end
   end

   // A load overrides the increment; the word leaving this cycle already saw the old address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_addr   <= BASE_ADDR;
         word_count <= '0;
      end else begin
         if (addr_load_en)
            out_addr <= {addr_load_value[31:2], 2'b00};
         else if (pop)
            out_addr <= out_addr + 32'd4;
         if (pop && word_count != '1)
            word_count <= word_count + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_valid  <= 1'b0;
         err_code   <= ENC_OK;
         err_sticky <= 1'b0;
      end else begin
         err_valid <= accept && (pack_err != ENC_OK);
         if (accept && pack_err != ENC_OK) begin
            err_code   <= pack_err;
            err_sticky <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: hand-encoded RV32I words, buffer
// backpressure, validation errors, address reload and asynchronous reset.
module tb_inst_encoder;
   import inst_encoder_pkg::*;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   RiscvInstructions in_operation = NOP;
   logic [4:0]       in_rd = '0, in_rs1 = '0, in_rs2 = '0;
   logic [31:0]      in_imm = '0;
   logic             addr_load_en = 1'b0;
   logic [31:0]      addr_load_value = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_instruction;
   logic [31:0]      out_addr;
   logic             err_valid;
   EncErrCode        err_code;
   logic             err_sticky;
   logic [15:0]      word_count;

   int total = 0;
   int bad   = 0;

   inst_encoder #(.BASE_ADDR(32'h0000_0000), .COUNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_operation(in_operation),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .addr_load_en(addr_load_en), .addr_load_value(addr_load_value),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instruction(out_instruction), .out_addr(out_addr),
      .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   // Presents one field set from a falling edge and returns on the next falling edge.
   task automatic drive(input RiscvInstructions op, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im);
      in_valid = 1'b1; in_operation = op; in_rd = d; in_rs1 = s1; in_rs2 = s2; in_imm = im;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      out_ready = 1'b0;
      addr_load_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0h want=0", out_valid); end
      total++; if (out_instruction !== 32'h0) begin bad++; $display("FAIL reset_out_instruction got=%h want=0", out_instruction); end
      total++; if (out_addr !== 32'h0) begin bad++; $display("FAIL reset_out_addr got=%h want=0", out_addr); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0h want=1", in_ready); end
      total++; if (word_count !== 16'd0) begin bad++; $display("FAIL reset_word_count got=%0d want=0", word_count); end
      total++; if (err_valid !== 1'b0 || err_sticky !== 1'b0) begin bad++; $display("FAIL reset_err_flags got=%0b%0b want=00", err_valid, err_sticky); end
      total++; if (err_code !== ENC_OK) begin bad++; $display("FAIL reset_err_code got=%0d want=%0d", err_code, ENC_OK); end
      rst = 1'b0;
   endtask

   task automatic test_addi();
      apply_reset();
      out_ready = 1'b1;
      drive(ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL addi_out_valid got=%0h want=1", out_valid); end
      total++; if (out_instruction !== 32'h0050_0093) begin bad++; $display("FAIL addi_word got=%h want=00500093", out_instruction); end
      total++; if (out_addr !== 32'h0) begin bad++; $display("FAIL addi_addr got=%h want=0", out_addr); end
      @(negedge clk);
      total++; if (word_count !== 16'd1) begin bad++; $display("FAIL addi_word_count got=%0d want=1", word_count); end
      total++; if (out_valid !== 1'b0 || out_addr !== 32'h4) begin bad++; $display("FAIL addi_after_handoff got=%0b/%h want=0/00000004", out_valid, out_addr); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      drive(ADD, 5'd3, 5'd1, 5'd2, 32'd0);
      total++; if (out_instruction !== 32'h0020_81B3) begin bad++; $display("FAIL b2b_first got=%h want=002081b3", out_instruction); end
      drive(SUB, 5'd3, 5'd1, 5'd2, 32'd0);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_in_ready_full got=%0h want=0", in_ready); end
      total++; if (out_instruction !== 32'h0020_81B3) begin bad++; $display("FAIL b2b_hold1 got=%h want=002081b3", out_instruction); end
      @(negedge clk);
      total++; if (out_valid !== 1'b1 || out_instruction !== 32'h0020_81B3) begin bad++; $display("FAIL b2b_hold2 got=%0b/%h want=1/002081b3", out_valid, out_instruction); end
      out_ready = 1'b1;
      total++; if (out_addr !== 32'h0) begin bad++; $display("FAIL b2b_addr0 got=%h want=0", out_addr); end
      @(negedge clk);
      total++; if (out_instruction !== 32'h4020_81B3) begin bad++; $display("FAIL b2b_second got=%h want=402081b3", out_instruction); end
      total++; if (out_addr !== 32'h4) begin bad++; $display("FAIL b2b_addr4 got=%h want=4", out_addr); end
      @(negedge clk);
      total++; if (word_count !== 16'd2 || out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_drain got=%0d/%0b/%0b want=2/0/1", word_count, out_valid, in_ready); end
      out_ready = 1'b0;
   endtask

   task automatic test_encodings();
      RiscvInstructions ops[12];
      logic [4:0]       rds[12], r1s[12], r2s[12];
      logic [31:0]      imms[12], words[12];
      ops[0]  = BEQ;    rds[0]  = 0; r1s[0]  = 1; r2s[0]  = 2; imms[0]  = 32'd8;          words[0]  = 32'h0020_8463;
      ops[1]  = SW;     rds[1]  = 0; r1s[1]  = 1; r2s[1]  = 2; imms[1]  = 32'd4;          words[1]  = 32'h0020_A223;
      ops[2]  = LUI;    rds[2]  = 5; r1s[2]  = 0; r2s[2]  = 0; imms[2]  = 32'h1234_5000;  words[2]  = 32'h1234_52B7;
      ops[3]  = SRAI;   rds[3]  = 1; r1s[3]  = 2; r2s[3]  = 0; imms[3]  = 32'd3;          words[3]  = 32'h4031_5093;
      ops[4]  = JAL;    rds[4]  = 1; r1s[4]  = 0; r2s[4]  = 0; imms[4]  = 32'd8;          words[4]  = 32'h0080_00EF;
      ops[5]  = BNE;    rds[5]  = 0; r1s[5]  = 0; r2s[5]  = 0; imms[5]  = -32'sd4;        words[5]  = 32'hFE00_1EE3;
      ops[6]  = NOP;    rds[6]  = 7; r1s[6]  = 7; r2s[6]  = 7; imms[6]  = 32'd123;        words[6]  = 32'h0000_0033;
      ops[7]  = EBREAK; rds[7]  = 0; r1s[7]  = 0; r2s[7]  = 0; imms[7]  = 32'd0;          words[7]  = 32'h0010_0073;
      ops[8]  = ECALL;  rds[8]  = 0; r1s[8]  = 0; r2s[8]  = 0; imms[8]  = 32'd0;          words[8]  = 32'h0000_0073;
      ops[9]  = FENCE;  rds[9]  = 0; r1s[9]  = 0; r2s[9]  = 0; imms[9]  = 32'h0FF;        words[9]  = 32'h0FF0_000F;
      ops[10] = ADDI;   rds[10] = 1; r1s[10] = 0; r2s[10] = 0; imms[10] = -32'sd2048;     words[10] = 32'h8000_0093;
      ops[11] = ADDI;   rds[11] = 1; r1s[11] = 0; r2s[11] = 0; imms[11] = 32'd2047;       words[11] = 32'h7FF0_0093;
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         drive(ops[i], rds[i], r1s[i], r2s[i], imms[i]);
         total++; if (out_valid !== 1'b1 || out_instruction !== words[i]) begin bad++; $display("FAIL enc_%0d_word got=%0b/%h want=1/%h", i, out_valid, out_instruction, words[i]); end
         total++; if (out_addr !== 32'(4 * i)) begin bad++; $display("FAIL enc_%0d_addr got=%h want=%h", i, out_addr, 32'(4 * i)); end
      end
      @(negedge clk);
      total++; if (word_count !== 16'd12) begin bad++; $display("FAIL enc_word_count got=%0d want=12", word_count); end
      total++; if (err_sticky !== 1'b0) begin bad++; $display("FAIL enc_no_error got=%0b want=0", err_sticky); end
      out_ready = 1'b0;
   endtask

   task automatic test_errors();
      RiscvInstructions ops[11];
      logic [31:0]      imms[11];
      EncErrCode        codes[11];
      ops[0]  = ADDI;  imms[0]  = 32'd2048;      codes[0]  = ENC_RANGE;
      ops[1]  = ADDI;  imms[1]  = -32'sd2049;    codes[1]  = ENC_RANGE;
      ops[2]  = SLLI;  imms[2]  = 32'd32;        codes[2]  = ENC_RANGE;
      ops[3]  = SW;    imms[3]  = 32'd2048;      codes[3]  = ENC_RANGE;
      ops[4]  = BEQ;   imms[4]  = 32'd4096;      codes[4]  = ENC_RANGE;
      ops[5]  = BEQ;   imms[5]  = 32'd5;         codes[5]  = ENC_ALIGN;
      ops[6]  = JAL;   imms[6]  = 32'd3;         codes[6]  = ENC_ALIGN;
      ops[7]  = JAL;   imms[7]  = 32'd1048575;   codes[7]  = ENC_ALIGN;
      ops[8]  = JAL;   imms[8]  = 32'd1048576;   codes[8]  = ENC_RANGE;
      ops[9]  = ERROR; imms[9]  = 32'd0;         codes[9]  = ENC_BAD_OP;
      ops[10] = RiscvInstructions'(6'd63); imms[10] = 32'd0; codes[10] = ENC_BAD_OP;
      apply_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         drive(ops[i], 5'd1, 5'd2, 5'd3, imms[i]);
         total++; if (err_valid !== 1'b1 || err_code !== codes[i]) begin bad++; $display("FAIL err_%0d_pulse got=%0b/%0d want=1/%0d", i, err_valid, err_code, codes[i]); end
         total++; if (out_valid !== 1'b0 || err_sticky !== 1'b1) begin bad++; $display("FAIL err_%0d_flags got=%0b/%0b want=0/1", i, out_valid, err_sticky); end
         @(negedge clk);
         total++; if (err_valid !== 1'b0 || err_code !== codes[i]) begin bad++; $display("FAIL err_%0d_after got=%0b/%0d want=0/%0d", i, err_valid, err_code, codes[i]); end
      end
      total++; if (word_count !== 16'd0 || out_addr !== 32'h0) begin bad++; $display("FAIL err_nothing_emitted got=%0d/%h want=0/0", word_count, out_addr); end
      out_ready = 1'b0;
   endtask

   task automatic test_addr_load();
      apply_reset();
      drive(ADDI, 5'd1, 5'd0, 5'd0, 32'd1);
      drive(ADDI, 5'd2, 5'd0, 5'd0, 32'd2);
      out_ready = 1'b1;
      addr_load_en = 1'b1;
      addr_load_value = 32'h0000_1003;
      total++; if (out_addr !== 32'h0 || out_instruction !== 32'h0010_0093) begin bad++; $display("FAIL load_old_addr got=%h/%h want=00000000/00100093", out_addr, out_instruction); end
      @(negedge clk);
      addr_load_en = 1'b0;
      total++; if (out_addr !== 32'h0000_1000 || out_instruction !== 32'h0020_0113) begin bad++; $display("FAIL load_new_addr got=%h/%h want=00001000/00200113", out_addr, out_instruction); end
      drive(ADDI, 5'd3, 5'd0, 5'd0, 32'd3);
      total++; if (out_addr !== 32'h0000_1004 || out_instruction !== 32'h0030_0193) begin bad++; $display("FAIL load_next_addr got=%h/%h want=00001004/00300193", out_addr, out_instruction); end
      @(negedge clk);
      total++; if (word_count !== 16'd3 || out_addr !== 32'h0000_1008) begin bad++; $display("FAIL load_drain got=%0d/%h want=3/00001008", word_count, out_addr); end
      out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      apply_reset();
      out_ready = 1'b1;
      drive(ADDI, 5'd1, 5'd0, 5'd0, 32'd5);
      drive(ADDI, 5'd1, 5'd0, 5'd0, 32'd4096);
      out_ready = 1'b0;
      drive(ADD, 5'd3, 5'd1, 5'd2, 32'd0);
      drive(SUB, 5'd3, 5'd1, 5'd2, 32'd0);
      total++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || word_count !== 16'd1 || err_sticky !== 1'b1) begin bad++; $display("FAIL arst_pre got=%0b/%0b/%0d/%0b want=1/0/1/1", out_valid, in_ready, word_count, err_sticky); end
      #2 rst = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL arst_handshake got=%0b/%0b want=0/1", out_valid, in_ready); end
      total++; if (out_addr !== 32'h0 || word_count !== 16'd0 || err_sticky !== 1'b0) begin bad++; $display("FAIL arst_state got=%h/%0d/%0b want=0/0/0", out_addr, word_count, err_sticky); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_addi();
      test_back_to_back();
      test_encodings();
      test_errors();
      test_addr_load();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inst_encoder.md
Name: inst_encoder

Overview:
- Inverse of the ID-stage decoder. Accepts one decoded operation (RiscvInstructions) plus rd/rs1/rs2/imm fields over a valid/ready handshake.
- Packs them into a 32-bit RV32I instruction word. Emits the word through a 2-entry output buffer with an auto-incrementing word address.
- Used by the boot/program loader and verification benches to write instruction memory. It is also the golden re-encoder for decoder round-trip checks.

Parameters:
- BASE_ADDR, 32'h0000_0000, out_addr value after reset.
- COUNT_W, 16, width of word_count.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input field set valid
- in_ready  out  1  encoder can accept a field set
- in_operation  in  RiscvInstructions  operation to encode
- in_rd  in  5  destination register
- in_rs1  in  5  source register 1
- in_rs2  in  5  source register 2
- in_imm  in  32  immediate as a signed byte offset or value (U-type uses [31:12])
- addr_load_en  in  1  reload the address counter
- addr_load_value  in  32  new address; bits [1:0] are ignored (forced 0)
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts the word
- out_instruction  out  32  encoded instruction
- out_addr  out  32  word address paired with out_instruction
- err_valid  out  1  one-cycle pulse: the input was rejected
- err_code  out  EncErrCode  reason for the last rejection
- err_sticky  out  1  set on any rejection; cleared only by rst
- word_count  out  COUNT_W  number of words handed off since reset

Behaviour:
Reset (rst=1, asynchronous):
- Buffer empty; out_valid=0; out_instruction=0.
- out_addr=BASE_ADDR; in_ready=1; word_count=0.
- err_valid=0; err_code=ENC_OK; err_sticky=0.

Handshakes:
- An input is accepted when in_valid & in_ready. An output word is handed off when out_valid & out_ready.
- in_ready is registered; it is 1 when the buffer occupancy is <2, or will be after this cycle's handoff.
- out_instruction is held stable while out_valid & ~out_ready.

Latency and ordering:
- A word accepted in cycle N is visible on out_valid at N+1 at the earliest.
- Words leave in FIFO order.

Buffer:
- 2 entries. Simultaneous accept and handoff when full is legal; occupancy stays at 2.
- Accept when occupancy is 2 and there is no handoff is impossible, because in_ready=0.

Encoding (standard RV32I opcode/funct3/funct7):
- R-type: rd, rs1, rs2; funct7[5]=1 for SUB/SRA.
- I-type: imm[11:0].
- Shift-immediate: shamt=imm[4:0], funct7[5]=1 for SRAI.
- S/B/J/U: standard bit scatter.
- NOP encodes as ADD x0,x0,x0 = 32'h0000_0033; field inputs are ignored.
- ECALL = 32'h0000_0073; EBREAK = 32'h0010_0073.
- FENCE = {imm[11:0],13'b0,7'b0001111}.

Validation: a failing input is accepted (consumes a handshake) but is not buffered. err_valid pulses at N+1 with the code, and err_sticky is set.
- ENC_BAD_OP: operation is ERROR or outside the enum.
- ENC_RANGE:
  - I/S imm outside [-2048, 2047];
  - shift imm outside [0, 31];
  - B imm outside [-4096, 4094];
  - J imm outside [-1048576, 1048574].
- ENC_ALIGN: B/J imm is odd. ALIGN takes priority over RANGE.

Address counter:
- Each handoff: out_addr += 4, wrapping modulo 2^32.
- addr_load_en: next out_addr = {addr_load_value[31:2],2'b00}.
  - If a handoff occurs in the same cycle, the handed-off word carries the old address; the load wins for the next word.
  - Words already buffered take the new address sequence. out_addr is the head-of-buffer address, not stored per entry.

word_count: +1 per handoff; saturates at all-ones.

Decomposition:
- package_project_typedefs gains:
  - EncErrCode enum {ENC_OK, ENC_BAD_OP, ENC_RANGE, ENC_ALIGN};
  - opcode localparams shared with RiscvOpcodes.
- Sub-module inst_pack: purely combinational. Inputs are operation and fields; outputs are the 32-bit word plus error code.
- Buffer, counters and error flags live in inst_encoder.

Test Plan:
- ADDI rd=1 rs1=0 imm=5, out_ready=1 -> out_instruction=32'h0050_0093 at N+1, out_addr=0, word_count=1.
- Back-to-back ADD x3,x1,x2 then SUB x3,x1,x2 with out_ready=0 for 3 cycles:
  - words 32'h0020_81B3 then 32'h4020_81B3 are held in order;
  - in_ready=0 after 2 accepts;
  - on release, out_addr=0 then 4.
- BEQ x1,x2,imm=8 -> 32'h0020_8463. SW x2,4(x1) -> 32'h0020_A223. LUI x5,imm=32'h1234_5000 -> 32'h1234_52B7.
- ADDI imm=2048 -> err_valid pulse, ENC_RANGE, no out_valid. JAL imm=3 -> ENC_ALIGN. ERROR op -> ENC_BAD_OP. err_sticky=1 after each.
- addr_load_en=1, addr_load_value=32'h0000_1003 in the same cycle as a handoff -> that word reports its old address; the next word reports 32'h0000_1000, then 32'h0000_1004.
- rst asserted mid-stream with 2 words buffered -> out_valid=0, out_addr=BASE_ADDR, word_count=0, err_sticky=0, in_ready=1, all immediately (asynchronous).
